li_sequencer: RTL and testbench

Load-immediate sequencer: turns a 32-bit constant plus destination register into the shortest MIPS instruction sequence (one or two words) that rebuilds it. This is the inverse of immediate extension. It picks the immediate form whose sign- or zero-extension reproduces the value and packs the 16-bit fields. It sits in the instruction-generation path, for example a boot/test-program loader feeding instruction memory, and emits words over a valid/ready stream.

---
 rtl/li_sequencer.sv | 122 ++++++++++++
 tb/tb_li_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/li_sequencer.sv
// Load-immediate sequencer: turns a 32-bit constant and a destination register
// into the shortest ADDIU / ORI / LUI / LUI+ORI MIPS sequence over a valid/ready stream.
module li_sequencer (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  input  logic [4:0]  in_rt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last
);

  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT1 = 2'd1,
    EMIT2 = 2'd2
  } state_t;

  // Returns {two_words, first_word}; first matching form wins.
  function automatic logic [32:0] first_word(input logic [31:0] value,
                                             input logic [4:0]  rt);
    logic [32:0] res;
    if (&value[31:15] || ~|value[31:15])
      res = {1'b0, OP_ADDIU, 5'd0, rt, value[15:0]};
    else if (~|value[31:16])
      res = {1'b0, OP_ORI, 5'd0, rt, value[15:0]};
    else if (~|value[15:0])
      res = {1'b0, OP_LUI, 5'd0, rt, value[31:16]};
    else
      res = {1'b1, OP_LUI, 5'd0, rt, value[31:16]};
    return res;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] lo_q;
  logic [4:0]  rt_q;
  logic        two_q;

  logic        accept;
  logic [32:0] first_sel;
  logic [31:0] second_word;
  logic        valid_d, last_d, ready_d;
  logic [31:0] instr_d;

  assign accept      = in_valid && in_ready;
  assign first_sel   = first_word(in_value, in_rt);
  assign second_word = {OP_ORI, rt_q, rt_q, lo_q};

  // Captured request: only the low half and rt are needed for the ORI word.
  always_ff @(posedge Clk) begin
    if (accept) begin
      lo_q  <= in_value[15:0];
      rt_q  <= in_rt;
      two_q <= first_sel[32];
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = out_valid;
    instr_d = out_instr;
    last_d  = out_last;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EMIT1;
          valid_d = 1'b1;
          instr_d = first_sel[31:0];
          last_d  = ~first_sel[32];
        end
      end
      EMIT1: begin
        if (out_ready) begin
          if (two_q) begin
            state_d = EMIT2;
            instr_d = second_word;
            last_d  = 1'b1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
      end
      EMIT2: begin
        if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  // in_ready is registered so it stays low until the first edge after reset release.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_instr <= 32'h0;
      out_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= ready_d;
      out_valid <= valid_d;
      out_instr <= instr_d;
      out_last  <= last_d;
    end
  end

endmodule

// File: tb/tb_li_sequencer.sv
// Bench for li_sequencer: table of constants with expected words, a scoreboard
// queue checked by a stream monitor, plus reset and back-to-back sequences.
module tb_li_sequencer;

  logic        Clk;
  logic        Rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic [4:0]  in_rt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;

  li_sequencer dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_rt     (in_rt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_last  (out_last)
  );

  typedef struct {
    logic [31:0] value;
    logic [4:0]  rt;
    int          stall;
    logic        two;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t        tbl [13];
  logic [32:0] sb [$];   // {last, instr}
  int          n_vec  = 0;
  int          n_miss = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stream monitor: every presented word must match the scoreboard head.
  always @(negedge Clk) begin
    if (Rst_n && out_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_word: got %h expected none (t=%0t)", out_instr, $time);
      end else begin
        check("mon_instr", out_instr, sb[0][31:0]);
        check("mon_last", {31'b0, out_last}, {31'b0, sb[0][32]});
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic push_exp(input vec_t v);
    if (v.two) begin
      sb.push_back({1'b0, v.w0});
      sb.push_back({1'b1, v.w1});
    end else begin
      sb.push_back({1'b1, v.w0});
    end
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic run_seq(input vec_t v);
    int   guard;
    logic acc;
    in_valid  = 1'b1;
    in_value  = v.value;
    in_rt     = v.rt;
    out_ready = (v.stall == 0);
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 20) begin
      acc = in_ready;
      if (acc) push_exp(v);
      @(posedge Clk); #1;
      guard++;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_value = $urandom;
    in_rt    = 5'($urandom);
    check("latency_valid", {31'b0, out_valid}, 32'd1);
    check("first_word", out_instr, v.w0);
    for (int i = 0; i < v.stall; i++) begin
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check("stall_hold", out_instr, v.w0);
      @(posedge Clk); #1;
    end
    out_ready = 1'b1;
    guard = 0;
    while (sb.size() != 0 && guard < 10) begin
      @(posedge Clk); #1;
      guard++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    check("done_valid", {31'b0, out_valid}, 32'd0);
    check("done_in_ready", {31'b0, in_ready}, 32'd1);
    check("hold_instr", out_instr, v.two ? v.w1 : v.w0);
  endtask

  initial begin
    tbl[0]  = '{32'h0000_7FFF, 5'd8,  0, 1'b0, 32'h2408_7FFF, 32'h0};
    tbl[1]  = '{32'hFFFF_8000, 5'd9,  0, 1'b0, 32'h2409_8000, 32'h0};
    tbl[2]  = '{32'h0000_8000, 5'd10, 0, 1'b0, 32'h340A_8000, 32'h0};
    tbl[3]  = '{32'h1234_0000, 5'd4,  0, 1'b0, 32'h3C04_1234, 32'h0};
    tbl[4]  = '{32'h0000_0000, 5'd0,  0, 1'b0, 32'h2400_0000, 32'h0};
    tbl[5]  = '{32'h1234_5678, 5'd4,  3, 1'b1, 32'h3C04_1234, 32'h3484_5678};
    tbl[6]  = '{32'hFFFF_FFFF, 5'd31, 0, 1'b0, 32'h241F_FFFF, 32'h0};
    tbl[7]  = '{32'h0001_0000, 5'd3,  1, 1'b0, 32'h3C03_0001, 32'h0};
    tbl[8]  = '{32'h8000_0000, 5'd1,  0, 1'b0, 32'h3C01_8000, 32'h0};
    tbl[9]  = '{32'hFFFF_7FFF, 5'd5,  0, 1'b1, 32'h3C05_FFFF, 32'h34A5_7FFF};
    tbl[10] = '{32'h0000_FFFF, 5'd6,  2, 1'b0, 32'h3406_FFFF, 32'h0};
    tbl[11] = '{32'hDEAD_BEEF, 5'd2,  0, 1'b1, 32'h3C02_DEAD, 32'h3442_BEEF};
    tbl[12] = '{32'h0000_0001, 5'd0,  0, 1'b0, 32'h2400_0001, 32'h0};

    Rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_value  = 32'h0;
    in_rt     = 5'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_last", {31'b0, out_last}, 32'd0);
    Rst_n = 1'b1;
    #1;
    check("release_in_ready_low", {31'b0, in_ready}, 32'd0);
    @(posedge Clk); #1;
    check("release_in_ready_high", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 13; i++) run_seq(tbl[i]);

    // Reset while the ORI word of a two-word sequence is held.
    in_valid  = 1'b1;
    in_value  = 32'h1234_5678;
    in_rt     = 5'd4;
    out_ready = 1'b1;
    push_exp(tbl[5]);
    @(posedge Clk); #1;
    in_valid = 1'b0;
    check("mid_w0", out_instr, 32'h3C04_1234);
    @(posedge Clk); #1;
    out_ready = 1'b0;
    check("mid_w1", out_instr, 32'h3484_5678);
    check("mid_last", {31'b0, out_last}, 32'd1);
    #3;
    Rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_out_last", {31'b0, out_last}, 32'd0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd0);
    check("arst_out_instr", out_instr, 32'h0);
    sb.delete();
    @(posedge Clk); #1;
    Rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge Clk); #1;
    check("arst_release_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("no_stale_word", {31'b0, out_valid}, 32'd0);
      @(posedge Clk); #1;
    end

    // Back-to-back with in_valid held high.
    in_valid = 1'b1;
    in_value = 32'h0000_0001;
    in_rt    = 5'd2;
    sb.push_back({1'b1, 32'h2402_0001});
    @(posedge Clk); #1;
    in_value = 32'hDEAD_BEEF;
    check("b2b_w_valid", {31'b0, out_valid}, 32'd1);
    check("b2b_w", out_instr, 32'h2402_0001);
    check("b2b_busy", {31'b0, in_ready}, 32'd0);
    @(posedge Clk); #1;
    check("b2b_idle_valid", {31'b0, out_valid}, 32'd0);
    check("b2b_idle_ready", {31'b0, in_ready}, 32'd1);
    push_exp(tbl[11]);
    @(posedge Clk); #1;
    in_valid = 1'b0;
    check("b2b_lui", out_instr, 32'h3C02_DEAD);
    check("b2b_lui_last", {31'b0, out_last}, 32'd0);
    @(posedge Clk); #1;
    check("b2b_ori", out_instr, 32'h3442_BEEF);
    check("b2b_ori_last", {31'b0, out_last}, 32'd1);
    @(posedge Clk); #1;
    check("b2b_end_valid", {31'b0, out_valid}, 32'd0);
    check("b2b_end_ready", {31'b0, in_ready}, 32'd1);
    check("b2b_sb_empty", sb.size(), 32'd0);

    @(posedge Clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
